// File: rtl/alu_8bit_pkg.sv
// Shared widths and opcode encoding for the 8-bit ALU slice.
package alu_8bit_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_8bit_comb.sv
// Purely combinational result and flag generator; no clock, no reset.
module alu_8bit_comb
  import alu_8bit_pkg::*;
(
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [RES_W-1:0]  res_o,
  output logic              cout_o,
  output logic              bout_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [RES_W-1:0]  prod;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
  // Divider is gated so a zero divisor never reaches the operator.
  assign quot = (b_i == '0) ? '0 : a_i / b_i;
  assign rem  = (b_i == '0) ? '0 : a_i % b_i;

  always_comb begin
    res_o  = '0;
    cout_o = 1'b0;
    bout_o = 1'b0;
    case (alu_op_e'(opcode_i))
      OP_ADD: begin
        res_o[DATA_W-1:0] = sum[DATA_W-1:0];
        cout_o            = sum[DATA_W];
      end
      OP_SUB: begin
        res_o[DATA_W-1:0] = diff[DATA_W-1:0];
        bout_o            = diff[DATA_W];
      end
      OP_MUL:  res_o = prod;
      OP_DIV:  res_o = (b_i == '0) ? {RES_W{1'b1}} : {rem, quot};
      OP_SHL:  res_o[DATA_W-1:0] = {a_i[DATA_W-2:0], 1'b0};
      OP_SHR:  res_o[DATA_W-1:0] = {1'b0, a_i[DATA_W-1:1]};
      OP_ROL:  res_o[DATA_W-1:0] = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
      OP_ROR:  res_o[DATA_W-1:0] = {a_i[0], a_i[DATA_W-1:1]};
      OP_AND:  res_o[DATA_W-1:0] = a_i & b_i;
      OP_OR:   res_o[DATA_W-1:0] = a_i | b_i;
      OP_XOR:  res_o[DATA_W-1:0] = a_i ^ b_i;
      OP_NOR:  res_o[DATA_W-1:0] = ~(a_i | b_i);
      OP_NAND: res_o[DATA_W-1:0] = ~(a_i & b_i);
      OP_XNOR: res_o[DATA_W-1:0] = ~(a_i ^ b_i);
      OP_GT:   res_o[0] = (a_i > b_i);
      OP_EQ:   res_o[0] = (a_i == b_i);
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_8bit_core.sv
// Registered 8-bit ALU: combinational core followed by one output register stage.
module alu_8bit_core
  import alu_8bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [RES_W-1:0]  alu_out,
  output logic              cout,
  output logic              bout
);

  logic [RES_W-1:0] alu_out_d, alu_out_q;
  logic             cout_d, cout_q;
  logic             bout_d, bout_q;

  alu_8bit_comb u_comb (
    .opcode_i (opcode),
    .a_i      (operand_a),
    .b_i      (operand_b),
    .res_o    (alu_out_d),
    .cout_o   (cout_d),
    .bout_o   (bout_d)
  );

  // Output register stage; reset discards whatever operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      cout_q    <= 1'b0;
      bout_q    <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      cout_q    <= cout_d;
      bout_q    <= bout_d;
    end
  end

  assign alu_out = alu_out_q;
  assign cout    = cout_q;
  assign bout    = bout_q;

endmodule

// File: tb/tb_alu_8bit_core.sv
// Directed and random checks of alu_8bit_core against an arithmetic reference model.
module tb_alu_8bit_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic [15:0] alu_out;
  logic        cout;
  logic        bout;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] exp_q;
  logic        exp_vld = 1'b0;

  alu_8bit_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_out   (alu_out),
    .cout      (cout),
    .bout      (bout)
  );

  always #5 clk = ~clk;

  // Reference: returns {cout, bout, alu_out} from plain integer arithmetic.
  function automatic logic [17:0] model(input int op, input int a, input int b);
    int res;
    int c;
    int bo;
    res = 0; c = 0; bo = 0;
    case (op)
      0:  begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1:  begin res = (a - b + 256) % 256; bo = (a < b) ? 1 : 0; end
      2:  res = a * b;
      3:  res = (b == 0) ? 65535 : (a % b) * 256 + a / b;
      4:  res = (a * 2) % 256;
      5:  res = a / 2;
      6:  res = (a * 2) % 256 + a / 128;
      7:  res = a / 2 + (a % 2) * 128;
      8:  res = a & b;
      9:  res = a | b;
      10: res = a ^ b;
      11: res = 255 - (a | b);
      12: res = 255 - (a & b);
      13: res = 255 - (a ^ b);
      14: res = (a > b) ? 1 : 0;
      default: res = (a == b) ? 1 : 0;
    endcase
    model = {c[0], bo[0], res[15:0]};
  endfunction

  // Capture model expectation at each edge; compare on the opposite edge.
  always @(posedge clk) begin
    if (!rst_n) exp_vld = 1'b0;
    else begin
      exp_q   = model(int'(opcode), int'(operand_a), int'(operand_b));
      exp_vld = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_vld) begin
      n_cmp++;
      if ({cout, bout, alu_out} !== exp_q) begin
        n_bad++;
        $display("FAIL model op=%0d actual=%h required=%h", opcode, {cout, bout, alu_out}, exp_q);
      end
    end
  end

  task automatic check(input string name, input logic [17:0] req);
    n_cmp++;
    if ({cout, bout, alu_out} !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, {cout, bout, alu_out}, req);
    end
  endtask

  task automatic apply(input string name, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [17:0] req);
    @(negedge clk);
    opcode = op; operand_a = a; operand_b = b;
    @(posedge clk);
    #1 check(name, req);
  endtask

  logic [15:0] shl_exp [4:13];

  initial begin
    shl_exp[4]  = 16'h0002; shl_exp[5]  = 16'h0040; shl_exp[6]  = 16'h0003;
    shl_exp[7]  = 16'h00C0; shl_exp[8]  = 16'h0080; shl_exp[9]  = 16'h00F1;
    shl_exp[10] = 16'h0071; shl_exp[11] = 16'h000E; shl_exp[12] = 16'h007F;
    shl_exp[13] = 16'h008E;

    rst_n = 1'b1; opcode = 4'd2; operand_a = 8'hFF; operand_b = 8'hFF;
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", 18'h0);
    @(posedge clk); #1 check("reset_held", 18'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 check("post_reset_mul", {2'b00, 16'hFE01});

    apply("add_carry",  4'd0, 8'hFF, 8'h01, {2'b10, 16'h0000});
    apply("add_plain",  4'd0, 8'h12, 8'h34, {2'b00, 16'h0046});
    apply("sub_borrow", 4'd1, 8'h05, 8'h0A, {2'b01, 16'h00FB});
    apply("sub_plain",  4'd1, 8'h0A, 8'h05, {2'b00, 16'h0005});
    apply("mul_max",    4'd2, 8'hFF, 8'hFF, {2'b00, 16'hFE01});
    apply("div_100_7",  4'd3, 8'd100, 8'd7, {2'b00, 16'h020E});
    apply("div_zero",   4'd3, 8'd100, 8'd0, {2'b00, 16'hFFFF});
    for (int op = 4; op <= 13; op++)
      apply($sformatf("logic_op%0d", op), 4'(op), 8'b1000_0001, 8'hF0, {2'b00, shl_exp[op]});
    apply("gt_true",    4'd14, 8'd9, 8'd8, {2'b00, 16'h0001});
    apply("eq_true",    4'd15, 8'h5A, 8'h5A, {2'b00, 16'h0001});
    apply("eq_false",   4'd15, 8'h5A, 8'h5B, {2'b00, 16'h0000});

    // Mid-stream reset: outputs hold a nonzero result, then clear without an edge.
    @(negedge clk); opcode = 4'd2; operand_a = 8'hFF; operand_b = 8'hFF;
    @(posedge clk); #1 check("pre_reset_mul", {2'b00, 16'hFE01});
    #2 rst_n = 1'b0;
    #1 check("midstream_reset", 18'h0);
    @(posedge clk); #1 check("midstream_reset_held", 18'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 check("midstream_release", {2'b00, 16'hFE01});

    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      opcode    = 4'(i % 16);
      operand_a = 8'($urandom_range(0, 255));
      operand_b = (i % 23 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_8bit_core.md
Name:
alu_8bit_core

Overview:
- Registered 8-bit combinational-arithmetic ALU with 16 operations selected by a 4-bit opcode.
- Produces a 16-bit result, so multiply and divide results fit without truncation, plus separate carry-out and borrow-out flags.
- Used as a leaf datapath unit fed by a controller or sequencer.
- All outputs are registered with one-cycle latency.

Parameters:
- none; widths are fixed: operands 8, opcode 4, result 16.

Ports:
- clk  input  1  — system clock; all state updates on the rising edge.
- rst_n  input  1  — asynchronous active-low reset.
- opcode  input  4  — operation select.
- operand_a  input  8  — first operand, unsigned.
- operand_b  input  8  — second operand, unsigned.
- alu_out  output  16  — registered result.
- cout  output  1  — registered carry-out; meaningful only for ADD.
- bout  output  1  — registered borrow-out; meaningful only for SUB.

Behaviour:
- Reset: rst_n low immediately forces alu_out=16'h0000, cout=0, bout=0. These hold until the first rising clk edge after rst_n deasserts.
- Latency: on each rising clk edge, the result of the opcode/operands sampled at that edge appears on the outputs. Latency is 1 cycle, throughput is 1 operation per cycle, and there is no handshake.
- All operands are unsigned.
- Unless an operation says otherwise: alu_out[15:8]=0, cout=0, bout=0.
- Opcode map (a=operand_a, b=operand_b):
  - 0 ADD: alu_out[7:0]=(a+b) mod 256; cout=bit 8 of the 9-bit sum.
  - 1 SUB: alu_out[7:0]=(a−b) mod 256; bout=1 iff a<b.
  - 2 MUL: alu_out=a*b, full 16 bits.
  - 3 DIV: alu_out={a mod b, a / b}, i.e. remainder in [15:8] and quotient in [7:0]. If b=0, alu_out=16'hFFFF.
  - 4 SHL: alu_out[7:0]=a<<1, with a[7] lost.
  - 5 SHR: alu_out[7:0]=a>>1, logical, zero-fill.
  - 6 ROL: alu_out[7:0]={a[6:0],a[7]}.
  - 7 ROR: alu_out[7:0]={a[0],a[7:1]}.
  - 8 AND: a&b.
  - 9 OR: a|b.
  - 10 XOR: a^b.
  - 11 NOR: ~(a|b).
  - 12 NAND: ~(a&b).
  - 13 XNOR: ~(a^b).
  - 14 GT: alu_out=16'h0001 if a>b, else 16'h0000.
  - 15 EQ: alu_out=16'h0001 if a==b, else 16'h0000.
- Shifts and rotates use operand_a only; operand_b is ignored.
- All 16 opcode values are defined; there is no illegal-opcode case.
- Reset asserted mid-stream clears the outputs asynchronously. The operation in flight is discarded, not replayed.
- No X propagation: every output bit is driven from a register after reset.

Decomposition:
- Shared package alu_8bit_pkg holds:
  - a typedef enum logic[3:0] for the opcodes: OP_ADD..OP_EQ, values as listed above;
  - localparams DATA_W=8 and RES_W=16.
- One natural sub-module, alu_8bit_comb: a purely combinational result/flag generator with no clock or reset.
- alu_8bit_core instantiates alu_8bit_comb and adds the output register stage with asynchronous reset.

Test Plan:
- Reset: rst_n=0 with opcode=2, a=8'hFF, b=8'hFF → alu_out=0, cout=0, bout=0 immediately, without waiting for a clock edge. After release, the next edge → alu_out=16'hFE01.
- ADD carry: opcode=0, a=8'hFF, b=8'h01 → one cycle later alu_out=16'h0000, cout=1, bout=0. Then a=8'h12, b=8'h34 → alu_out=16'h0046, cout=0.
- SUB borrow: opcode=1, a=8'h05, b=8'h0A → alu_out=16'h00FB, bout=1. Then a=8'h0A, b=8'h05 → alu_out=16'h0005, bout=0.
- MUL/DIV:
  - opcode=2, a=8'hFF, b=8'hFF → 16'hFE01.
  - opcode=3, a=8'd100, b=8'd7 → 16'h020E.
  - opcode=3, a=8'd100, b=0 → 16'hFFFF.
- Shift/logic: a=8'b1000_0001, b=8'hF0:
  - opcode 4 → 16'h0002
  - opcode 5 → 16'h0040
  - opcode 6 → 16'h0003
  - opcode 7 → 16'h00C0
  - opcode 8 → 16'h0080
  - opcode 9 → 16'h00F1
  - opcode 10 → 16'h0071
  - opcode 11 → 16'h000E
  - opcode 12 → 16'h007F
  - opcode 13 → 16'h008E
- Compare plus random sweep:
  - opcode 14 with a=9, b=8 → 16'h0001; opcode 15 with a=b=8'h5A → 16'h0001; opcode 15 with a=8'h5A, b=8'h5B → 16'h0000.
  - Then all 16 opcodes with random operands, changed every cycle, checked against a reference model with a one-cycle delay.
